// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// Holds the FSM encoding, default geometry and the latency-counter load helper.
package dmem_responder_pkg;

  localparam int DataWidth   = 32;
  localparam int DmemAddrW   = 10;
  localparam int DmemLatency = 2;
  localparam int ByteSelW    = 4;
  localparam int CntW        = 4;

  typedef logic [ByteSelW-1:0] byte_sel_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // The accept cycle and the RESP cycle each take one cycle of the latency,
  // so WAIT counts down from LATENCY-2; LATENCY==1 skips WAIT entirely.
  function automatic logic [CntW-1:0] latencyLoad(input int latency);
    return (latency > 1) ? CntW'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte synchronous write enables and a registered read port.
// Deliberately has no reset so it can map onto block RAM.
module dmem_array #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < DW / 8; k++) begin
      if (we_i && be_i[k]) begin
        mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MEM-stage load/store port: captures one access, holds it for a
// fixed latency, performs it on dmem_array and returns a one-cycle ack.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DW      = DataWidth,
  parameter int AW      = DmemAddrW,
  parameter int LATENCY = DmemLatency
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            stall_req
);

  localparam logic [CntW-1:0] CntLoad = latencyLoad(LATENCY);

  dmem_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             we_q;
  logic [29:0]      addr_q;
  logic [DW/8-1:0]  sel_q;
  logic [DW-1:0]    wdata_q;

  logic             accept;
  logic             rangeErr;
  logic             memWe;
  logic [AW-1:0]    memRaddr;
  logic [DW-1:0]    memRdata;
  logic             addr_unused;

  assign accept      = (state_q == DMEM_IDLE) && req_i;
  assign rangeErr    = |addr_q[29:AW];
  assign addr_unused = ^addr_i[1:0];
  assign stall_req   = req_i & ~ack_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i[31:2];
        sel_q   <= sel_i;
        wdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (req_i) begin
          if (LATENCY == 1) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CntLoad;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // In IDLE the read port follows the live address so a LATENCY==1 read is
  // already registered when RESP begins; afterwards it tracks the captured copy.
  always_comb begin
    ack_o    = (state_q == DMEM_RESP);
    err_o    = ack_o & rangeErr;
    memWe    = ack_o & we_q & ~rangeErr;
    rdata_o  = (ack_o && !we_q && !rangeErr) ? memRdata : '0;
    memRaddr = (state_q == DMEM_IDLE) ? addr_i[AW+1:2] : addr_q[AW-1:0];
  end

  dmem_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk     (clk),
    .we_i    (memWe),
    .be_i    (sel_q),
    .waddr_i (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (memRaddr),
    .rdata_o (memRdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 4) driven by directed tables,
// hand-written corner sequences and random traffic checked against a word/byte model.
module tb_dmem_responder;

  localparam int NumDut = 3;

  logic        clk;
  logic        rst_n;
  logic        req   [NumDut];
  logic        we    [NumDut];
  logic [31:0] addr  [NumDut];
  logic [3:0]  sel   [NumDut];
  logic [31:0] wdata [NumDut];
  logic [31:0] rdata [NumDut];
  logic        ack   [NumDut];
  logic        err   [NumDut];
  logic        stall [NumDut];

  int testsRun    = 0;
  int testsFailed = 0;
  int curDut      = 0;

  logic [31:0] model [NumDut][1024];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    bit          expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [10];

  for (genvar g = 0; g < NumDut; g++) begin : gDut
    dmem_responder #(
      .DW(32),
      .AW(10),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req[g]),
      .we_i      (we[g]),
      .addr_i    (addr[g]),
      .sel_i     (sel[g]),
      .wdata_i   (wdata[g]),
      .rdata_o   (rdata[g]),
      .ack_o     (ack[g]),
      .err_o     (err[g]),
      .stall_req (stall[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  // Reference behaviour: 4 KiB of words, anything above byte 0xFFF is an error.
  function automatic void modelAccess(input int d, input bit w, input logic [31:0] a,
                                      input logic [3:0] s, input logic [31:0] wd,
                                      output bit e, output logic [31:0] r);
    int wi;
    e  = (a >> 12) != 0;
    r  = 32'h0;
    wi = int'(a[11:2]);
    if (!e) begin
      if (w) begin
        for (int k = 0; k < 4; k++) begin
          if (s[k]) model[d][wi][8*k +: 8] = wd[8*k +: 8];
        end
      end else begin
        r = model[d][wi];
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL dut%0d %s: got 0x%08h, expected 0x%08h",
               curDut, name, actual, expected);
    end
  endtask

  // Called at posedge+1. b2b means the request is presented in the previous ack cycle.
  task automatic applyStimulus(input int d, input bit w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] wd,
                               input bit b2b, input bit keepReq, input bit mutate,
                               output logic gotErr, output logic [31:0] gotRdata);
    int   lat;
    int   expN;
    int   n;
    int   stallCnt;
    bit   seen;
    logic stallAtAck;
    curDut     = d;
    lat        = latOf(d);
    expN       = lat + (b2b ? 1 : 0);
    n          = 0;
    stallCnt   = 0;
    seen       = 1'b0;
    stallAtAck = 1'bx;
    gotErr     = 1'bx;
    gotRdata   = 32'hxxxxxxxx;
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    sel[d]   = s;
    wdata[d] = wd;
    if (!b2b) begin
      #1;
      if (stall[d] === 1'b1) stallCnt++;
    end
    while (!seen && n < expN + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (ack[d] === 1'b1) begin
        seen       = 1'b1;
        stallAtAck = stall[d];
        gotErr     = err[d];
        gotRdata   = rdata[d];
      end else begin
        if (stall[d] === 1'b1) stallCnt++;
        if (mutate && n == (b2b ? 2 : 1)) begin
          addr[d]  = a ^ 32'h4;
          wdata[d] = ~wd;
        end
      end
    end
    checkOutput("ackSeen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("latency", n, expN);
      checkOutput("stallAtAck", 32'(stallAtAck), 32'd0);
      checkOutput("stallCycles", stallCnt, lat);
    end
    if (!keepReq) begin
      req[d] = 1'b0;
      we[d]  = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ackPulse", 32'(ack[d]), 32'd0);
      checkOutput("idleStall", 32'(stall[d]), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    bit          me;
    logic [31:0] mr;
    bit          prevKeep;
    bit          keep;
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;

    vecs[0] = '{1'b1, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0040, 4'b0000, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0040, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0040, 4'b0100, 32'h00BB_0000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0040, 4'b0001, 32'h0,         1'b0, 32'hDEBB_BEAA};
    vecs[5] = '{1'b1, 32'h0000_1000, 4'b1111, 32'h1234_5678, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0,         1'b0, 32'hA5A5_0000};
    vecs[7] = '{1'b0, 32'h8000_0000, 4'b1111, 32'h0,         1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_0043, 4'b0000, 32'h0,         1'b0, 32'hDEBB_BEAA};
    vecs[9] = '{1'b1, 32'h0000_0044, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0};

    rst_n = 1'b0;
    for (int d = 0; d < NumDut; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; sel[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known contents for the 32-word window the rest of the bench touches.
    for (int d = 0; d < NumDut; d++) begin
      for (int i = 0; i < 32; i++) begin
        applyStimulus(d, 1'b1, 32'(i * 4), 4'hF, 32'hA5A5_0000 | 32'(i), 1'b0, 1'b0, 1'b0, e, r);
        modelAccess(d, 1'b1, 32'(i * 4), 4'hF, 32'hA5A5_0000 | 32'(i), me, mr);
      end
    end

    // Reset in the middle of outstanding accesses.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; sel[0] = 4'hF; wdata[0] = '0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; sel[1] = 4'hF; wdata[1] = 32'hFFFF_FFFF;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; wdata[2] = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int d = 0; d < NumDut; d++) req[d] = 1'b0;
    #1;
    for (int d = 0; d < NumDut; d++) begin
      curDut = d;
      checkOutput("rstAck", 32'(ack[d]), 32'd0);
      checkOutput("rstStall", 32'(stall[d]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < NumDut; d++) begin
      curDut = d;
      checkOutput("postRstAck", 32'(ack[d]), 32'd0);
      checkOutput("postRstErr", 32'(err[d]), 32'd0);
      checkOutput("postRstStall", 32'(stall[d]), 32'd0);
      checkOutput("postRstRdata", rdata[d], 32'd0);
    end
    for (int d = 0; d < NumDut; d++) begin
      applyStimulus(d, 1'b0, 32'h40, 4'hF, '0, 1'b0, 1'b0, 1'b0, e, r);
      checkOutput("abortedStore", r, 32'hA5A5_0010);
      applyStimulus(d, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0, 1'b0, e, r);
      checkOutput("read10Err", 32'(e), 32'd0);
      checkOutput("read10Data", r, 32'hA5A5_0004);
    end

    for (int d = 0; d < NumDut; d++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(d, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].wd, 1'b0, 1'b0, 1'b0, e, r);
        modelAccess(d, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].wd, me, mr);
        checkOutput($sformatf("vec%0dErr", i), 32'(e), 32'(vecs[i].expErr));
        checkOutput($sformatf("vec%0dRdata", i), r, vecs[i].expRdata);
      end
      applyStimulus(d, 1'b0, 32'h44, 4'hF, '0, 1'b0, 1'b0, 1'b0, e, r);
      checkOutput("sel0Unchanged", r, 32'hA5A5_0011);
    end

    // Three loads with req held high, new address presented in each ack cycle.
    for (int d = 0; d < NumDut; d++) begin
      applyStimulus(d, 1'b0, 32'h04, 4'hF, '0, 1'b0, 1'b1, 1'b0, e, r);
      checkOutput("b2bFirst", r, 32'hA5A5_0001);
      applyStimulus(d, 1'b0, 32'h08, 4'hF, '0, 1'b1, 1'b1, 1'b0, e, r);
      checkOutput("b2bSecond", r, 32'hA5A5_0002);
      applyStimulus(d, 1'b0, 32'h0C, 4'hF, '0, 1'b1, 1'b0, 1'b0, e, r);
      checkOutput("b2bThird", r, 32'hA5A5_0003);
    end

    // Inputs changed after acceptance must not affect the access.
    for (int d = 0; d < NumDut; d++) begin
      applyStimulus(d, 1'b1, 32'h48, 4'hF, 32'h600D_CAFE, 1'b0, 1'b0, 1'b1, e, r);
      modelAccess(d, 1'b1, 32'h48, 4'hF, 32'h600D_CAFE, me, mr);
      applyStimulus(d, 1'b0, 32'h48, 4'hF, '0, 1'b0, 1'b0, 1'b0, e, r);
      checkOutput("mutateTarget", r, 32'h600D_CAFE);
      applyStimulus(d, 1'b0, 32'h4C, 4'hF, '0, 1'b0, 1'b0, 1'b0, e, r);
      checkOutput("mutateNeighbour", r, 32'hA5A5_0013);
    end

    for (int d = 0; d < NumDut; d++) begin
      prevKeep = 1'b0;
      for (int i = 0; i < 40; i++) begin
        w  = 1'($urandom_range(0, 1));
        a  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
        s  = 4'($urandom);
        wd = $urandom;
        keep = (i != 39) && ($urandom_range(0, 1) == 1);
        applyStimulus(d, w, a, s, wd, prevKeep, keep, 1'b0, e, r);
        modelAccess(d, w, a, s, wd, me, mr);
        checkOutput($sformatf("rnd%0dErr", i), 32'(e), 32'(me));
        checkOutput($sformatf("rnd%0dRdata", i), r, mr);
        prevKeep = keep;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
